quad_enc_gen: RTL and testbench

Quadrature encoder signal generator: drives A/B phase outputs (plus an index) that step a 4-state Gray sequence toward a host-written target position, one quarter-cycle per programmable clock period. Used as the transmit side of the encoder interface: it emulates a physical encoder for loopback testing of the x1 decoder, and serves as a simulated axis for LinuxCNC position-loop bring-up. Sits on the Avalon-side register file and drives the encoder pins or an internal loopback.

---
 rtl/quad_enc_gen_if.sv | 27 ++
 rtl/quad_enc_gen.sv | 108 ++++++++++
 tb/tb_quad_enc_gen.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_enc_gen_if.sv
// Host-side bundle for the quadrature encoder generator: stepping controls in,
// A/B/index phases and position status out.
interface quad_enc_gen_if #(
   parameter int PERIOD_W = 16
);
   logic                enable;
   logic [31:0]         target;
   logic                target_load;
   logic [PERIOD_W-1:0] period;
   logic                enc_a;
   logic                enc_b;
   logic                enc_idx;
   logic [31:0]         position;
   logic                step_pulse;
   logic                dir;
   logic                busy;

   modport master (
      output enable, target, target_load, period,
      input  enc_a, enc_b, enc_idx, position, step_pulse, dir, busy
   );

   modport slave (
      input  enable, target, target_load, period,
      output enc_a, enc_b, enc_idx, position, step_pulse, dir, busy
   );
endinterface

// File: rtl/quad_enc_gen.sv
// Quadrature encoder emulator: walks the A/B Gray sequence one quarter-step per
// programmable period toward a host-loaded target position.
module quad_enc_gen #(
   parameter int CPR      = 4000,
   parameter int PERIOD_W = 16
) (
   input  logic          clk50,
   input  logic          reset,
   quad_enc_gen_if.slave bus
);
   localparam int                REV_W     = $clog2(CPR);
   localparam logic [REV_W-1:0]  REV_MAX   = REV_W'(CPR - 1);
   localparam logic [31:0]       POS_RESET = 32'h7FFF_FFFF;

   // Encoding is {A, B}, so the state bits drive the pins directly.
   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b10,
      S2 = 2'b11,
      S3 = 2'b01
   } phase_e;

   phase_e              phase_q, phase_d;
   logic [31:0]         position_q, position_d;
   logic [31:0]         target_q, target_d;
   logic [REV_W-1:0]    rev_pos_q, rev_pos_d;
   logic [PERIOD_W-1:0] timer_q, timer_d;
   logic                step_pulse_q, step_pulse_d;
   logic                dir_q, dir_d;
   logic                enc_idx_q, enc_idx_d;

   logic [31:0]         diff;
   logic                fwd;
   logic                step;
   logic [PERIOD_W-1:0] period_eff;

   always_comb begin
      // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
      phase_d      = phase_q;
      position_d   = position_q;
      target_d     = target_q;
      rev_pos_d    = rev_pos_q;
      timer_d      = timer_q;
      dir_d        = dir_q;
      step_pulse_d = 1'b0;

      // Modular difference read as signed picks the shorter signed direction.
      diff       = target_q - position_q;
      fwd        = ~diff[31];
      step       = bus.enable && (timer_q == '0) && (diff != 32'd0);
      period_eff = (bus.period == '0) ? PERIOD_W'(1) : bus.period;

      if (bus.target_load) target_d = bus.target;
      if (timer_q != '0)   timer_d  = timer_q - PERIOD_W'(1);

      if (step) begin
         step_pulse_d = 1'b1;
         dir_d        = fwd;
         timer_d      = period_eff - PERIOD_W'(1);
         if (fwd) begin
            position_d = position_q + 32'd1;
            rev_pos_d  = (rev_pos_q == REV_MAX) ? '0 : rev_pos_q + REV_W'(1);
         end else begin
            position_d = position_q - 32'd1;
            rev_pos_d  = (rev_pos_q == '0) ? REV_MAX : rev_pos_q - REV_W'(1);
         end
         case (phase_q)
            S0:      phase_d = fwd ? S1 : S3;
            S1:      phase_d = fwd ? S2 : S0;
            S2:      phase_d = fwd ? S3 : S1;
            default: phase_d = fwd ? S0 : S2;
         endcase
      end

      enc_idx_d = (rev_pos_d == '0);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk50) begin
      if (reset) begin
         phase_q      <= S0;
         position_q   <= POS_RESET;
         target_q     <= POS_RESET;
         rev_pos_q    <= '0;
         timer_q      <= '0;
         step_pulse_q <= 1'b0;
         dir_q        <= 1'b1;
         enc_idx_q    <= 1'b1;
      end else begin
         phase_q      <= phase_d;
         position_q   <= position_d;
         target_q     <= target_d;
         rev_pos_q    <= rev_pos_d;
         timer_q      <= timer_d;
         step_pulse_q <= step_pulse_d;
         dir_q        <= dir_d;
         enc_idx_q    <= enc_idx_d;
      end
   end

   assign bus.enc_a      = phase_q[1];
   assign bus.enc_b      = phase_q[0];
   assign bus.enc_idx    = enc_idx_q;
   assign bus.position   = position_q;
   assign bus.step_pulse = step_pulse_q;
   assign bus.dir        = dir_q;
   assign bus.busy       = (position_q != target_q);
endmodule

// File: tb/tb_quad_enc_gen.sv
// Directed bench for quad_enc_gen (CPR = 8): stepping cadence, phase order,
// index wrap, retarget, enable hold, reset mid-move and x1 decoder loopback.
module tb_quad_enc_gen;
   localparam logic [1:0] PH [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
   localparam logic [31:0] BASE = 32'h7FFF_FFFF;

   logic clk50 = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   dec_count = 0;
   logic [1:0] prev_ab = 2'b00;

   quad_enc_gen_if #(.PERIOD_W(16)) bus ();
   quad_enc_gen #(.CPR(8), .PERIOD_W(16)) dut (.clk50(clk50), .reset(reset), .bus(bus));

   always #10 clk50 = ~clk50;

   // x1 loopback decoder: +1 on S0->S1, -1 on S1->S0.
   always @(negedge clk50) begin
      if (prev_ab == 2'b00 && {bus.enc_a, bus.enc_b} == 2'b10) dec_count++;
      else if (prev_ab == 2'b10 && {bus.enc_a, bus.enc_b} == 2'b00) dec_count--;
      prev_ab = {bus.enc_a, bus.enc_b};
   end

   task automatic tick();
      @(posedge clk50);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.target_load = 1'b0;
      bus.enable = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
   endtask

   task automatic load(input logic [31:0] value);
      bus.target = value;
      bus.target_load = 1'b1;
      tick();
      bus.target_load = 1'b0;
   endtask

   task automatic wait_step(input int budget, output int waited);
      waited = 0;
      do begin
         tick();
         waited++;
      end while (!bus.step_pulse && waited < budget);
      checks++;
      if (bus.step_pulse !== 1'b1) begin
         errors++;
         $display("FAIL step_timeout: no step_pulse within %0d cycles", budget);
      end
   endtask

   task automatic test_reset();
      bus.target = '0;
      bus.period = 16'd1;
      do_reset();
      checks++;
      if ({bus.enc_a, bus.enc_b, bus.enc_idx, bus.step_pulse, bus.dir, bus.busy} !== 6'b001010) begin
         errors++;
         $display("FAIL reset_flags: got a,b,idx,pulse,dir,busy=%b expected 001010",
                  {bus.enc_a, bus.enc_b, bus.enc_idx, bus.step_pulse, bus.dir, bus.busy});
      end
      checks++;
      if (bus.position !== BASE) begin
         errors++;
         $display("FAIL reset_position: got %h expected %h", bus.position, BASE);
      end
   endtask

   task automatic test_forward();
      int w;
      do_reset();
      bus.period = 16'd10;
      load(BASE + 32'd8);
      for (int k = 0; k < 8; k++) begin
         wait_step(40, w);
         checks++;
         if (w !== ((k == 0) ? 1 : 10)) begin
            errors++;
            $display("FAIL fwd_spacing[%0d]: got %0d expected %0d", k, w, (k == 0) ? 1 : 10);
         end
         checks++;
         if ({bus.enc_a, bus.enc_b, bus.dir, bus.busy} !== {PH[(k + 1) % 4], 1'b1, (k != 7)}) begin
            errors++;
            $display("FAIL fwd_state[%0d]: got ab,dir,busy=%b expected %b", k,
                     {bus.enc_a, bus.enc_b, bus.dir, bus.busy}, {PH[(k + 1) % 4], 1'b1, (k != 7)});
         end
      end
      checks++;
      if (bus.position !== 32'h8000_0007 || bus.enc_idx !== 1'b1) begin
         errors++;
         $display("FAIL fwd_final: got pos=%h idx=%b expected 80000007 idx=1", bus.position, bus.enc_idx);
      end
   endtask

   task automatic test_reverse_wrap();
      int w;
      do_reset();
      bus.period = 16'd2;
      load(32'h7FFF_FFFC);
      for (int k = 0; k < 3; k++) begin
         wait_step(20, w);
         checks++;
         if ({bus.enc_a, bus.enc_b, bus.enc_idx, bus.dir} !== {PH[3 - k], 2'b00} || w !== ((k == 0) ? 1 : 2)) begin
            errors++;
            $display("FAIL rev_step[%0d]: got ab,idx,dir=%b gap=%0d expected %b gap=%0d", k,
                     {bus.enc_a, bus.enc_b, bus.enc_idx, bus.dir}, w, {PH[3 - k], 2'b00}, (k == 0) ? 1 : 2);
         end
      end
      checks++;
      if (bus.position !== 32'h7FFF_FFFC || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL rev_final: got pos=%h busy=%b expected 7ffffffc busy=0", bus.position, bus.busy);
      end
      load(BASE + 32'd16);
      for (int k = 0; k < 19; k++) begin
         wait_step(20, w);
         checks++;
         if (bus.enc_idx !== (k == 2 || k == 10 || k == 18)) begin
            errors++;
            $display("FAIL wrap_idx[%0d]: got %b expected %b", k, bus.enc_idx, (k == 2 || k == 10 || k == 18));
         end
      end
      checks++;
      if (bus.position !== 32'h8000_000F || bus.dir !== 1'b1) begin
         errors++;
         $display("FAIL wrap_final: got pos=%h dir=%b expected 8000000f dir=1", bus.position, bus.dir);
      end
   endtask

   task automatic test_max_rate();
      int c0;
      do_reset();
      bus.period = 16'd0;
      c0 = dec_count;
      load(BASE + 32'd5);
      tick();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.step_pulse !== 1'b1 || bus.position !== BASE + 32'(i + 1)) begin
            errors++;
            $display("FAIL max_rate[%0d]: got pulse=%b pos=%h expected 1 %h", i, bus.step_pulse,
                     bus.position, BASE + 32'(i + 1));
         end
         tick();
      end
      checks++;
      if (bus.step_pulse !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL max_rate_end: got pulse=%b busy=%b expected 0 0", bus.step_pulse, bus.busy);
      end
      checks++;
      if (dec_count - c0 !== 2) begin
         errors++;
         $display("FAIL loopback_fwd: got %0d expected 2", dec_count - c0);
      end
      bus.period = 16'd1;
      c0 = dec_count;
      load(BASE + 32'd2);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus.step_pulse !== 1'b1 || bus.dir !== 1'b0) begin
            errors++;
            $display("FAIL period1[%0d]: got pulse=%b dir=%b expected 1 0", i, bus.step_pulse, bus.dir);
         end
      end
      tick();
      checks++;
      if (bus.step_pulse !== 1'b0 || bus.position !== 32'h8000_0001 || dec_count - c0 !== -1) begin
         errors++;
         $display("FAIL period1_end: got pulse=%b pos=%h dec=%0d expected 0 80000001 -1",
                  bus.step_pulse, bus.position, dec_count - c0);
      end
   endtask

   task automatic test_retarget();
      int w;
      int stray;
      do_reset();
      bus.period = 16'd4;
      load(BASE + 32'd10);
      for (int k = 0; k < 4; k++) wait_step(20, w);
      checks++;
      if (bus.position !== 32'h8000_0003) begin
         errors++;
         $display("FAIL retarget_mid: got %h expected 80000003", bus.position);
      end
      load(BASE + 32'd2);
      for (int k = 0; k < 2; k++) begin
         wait_step(20, w);
         checks++;
         if (w !== ((k == 0) ? 3 : 4) || bus.dir !== 1'b0 || {bus.enc_a, bus.enc_b} !== PH[3 - k]) begin
            errors++;
            $display("FAIL retarget_step[%0d]: got gap=%0d dir=%b ab=%b expected gap=%0d dir=0 ab=%b", k, w,
                     bus.dir, {bus.enc_a, bus.enc_b}, (k == 0) ? 3 : 4, PH[3 - k]);
         end
      end
      stray = 0;
      repeat (20) begin
         tick();
         if (bus.step_pulse) stray++;
      end
      checks++;
      if (bus.position !== 32'h8000_0001 || bus.busy !== 1'b0 || stray !== 0) begin
         errors++;
         $display("FAIL retarget_end: got pos=%h busy=%b stray=%0d expected 80000001 0 0",
                  bus.position, bus.busy, stray);
      end
   endtask

   task automatic test_enable_hold();
      int w;
      logic [1:0]  ab;
      logic [31:0] pos;
      int          bad;
      do_reset();
      bus.period = 16'd3;
      load(BASE + 32'd10);
      wait_step(20, w);
      wait_step(20, w);
      bus.enable = 1'b0;
      ab  = {bus.enc_a, bus.enc_b};
      pos = bus.position;
      bad = 0;
      repeat (50) begin
         tick();
         if ({bus.enc_a, bus.enc_b} !== ab || bus.position !== pos || bus.step_pulse !== 1'b0
             || bus.busy !== 1'b1) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL enable_hold: got %0d changed cycles expected 0", bad);
      end
      bus.enable = 1'b1;
      wait_step(20, w);
      checks++;
      if (w !== 1) begin
         errors++;
         $display("FAIL enable_resume: got gap=%0d expected 1", w);
      end
      for (int k = 0; k < 7; k++) wait_step(20, w);
      checks++;
      if (bus.position !== BASE + 32'd10 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL enable_final: got pos=%h busy=%b expected %h 0", bus.position, bus.busy, BASE + 32'd10);
      end
   endtask

   task automatic test_reset_mid_move();
      int w;
      int stray;
      do_reset();
      bus.period = 16'd5;
      load(BASE + 32'd10);
      for (int k = 0; k < 4; k++) wait_step(20, w);
      repeat (4) tick();
      reset = 1'b1;
      tick();
      checks++;
      if ({bus.enc_a, bus.enc_b, bus.enc_idx, bus.step_pulse, bus.dir, bus.busy} !== 6'b001010
          || bus.position !== BASE) begin
         errors++;
         $display("FAIL reset_mid: got a,b,idx,pulse,dir,busy=%b pos=%h expected 001010 %h",
                  {bus.enc_a, bus.enc_b, bus.enc_idx, bus.step_pulse, bus.dir, bus.busy}, bus.position, BASE);
      end
      reset = 1'b0;
      stray = 0;
      repeat (20) begin
         tick();
         if (bus.step_pulse) stray++;
      end
      checks++;
      if (stray !== 0 || bus.position !== BASE) begin
         errors++;
         $display("FAIL reset_discard: got stray=%0d pos=%h expected 0 %h", stray, bus.position, BASE);
      end
   endtask

   initial begin
      bus.enable      = 1'b1;
      bus.target      = '0;
      bus.target_load = 1'b0;
      bus.period      = 16'd1;
      test_reset();
      test_forward();
      test_reverse_wrap();
      test_max_rate();
      test_retarget();
      test_enable_hold();
      test_reset_mid_move();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
